// File: rtl/spec_add_pkg.sv
// Shared constants and types for the speculative segmented adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spec_add_pkg;

  localparam int SEG_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of carry-speculation segments in an operand of the given width.
  function automatic int num_segs(input int width);
    return width / SEG_W;
  endfunction

endpackage

// File: rtl/seg_add3_pg.sv
// One SEG_W-bit ripple segment: sum/carry-out for the given carry-in plus group propagate/generate.
// Latency: purely combinational.
// Backpressure: none, no state.
module seg_add3_pg
  import spec_add_pkg::*;
(
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             p,
  output logic             g
);

  logic [SEG_W:0] raw;
  logic [SEG_W:0] full;

  // Generate is the carry-out with no carry-in, so it comes from the raw a+b.
  assign raw  = {1'b0, a} + {1'b0, b};
  assign full = raw + {{SEG_W{1'b0}}, cin};

  assign sum  = full[SEG_W-1:0];
  assign cout = full[SEG_W];
  assign p    = &(a ^ b);
  assign g    = raw[SEG_W];

endmodule

// File: rtl/spec_seg_adder_vl.sv
// Variable-latency speculative adder: segment carry-ins guessed from the previous segment's generate.
// Latency: result 2 cycles after accept, 3 when an exact-mode misspeculation is corrected.
// Backpressure: one operation in flight; in_ready low until the result is taken with out_ready.
module spec_seg_adder_vl
  import spec_add_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 ci,
  input  logic                 approx_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     s,
  output logic                 co,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int N = num_segs(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0]     a_q, b_q;
  logic                 ci_q, approx_q;

  logic [N-1:0]         p, g, cs, c_s;
  logic [N-1:0]         p_x, g_x, c_x;
  logic [N:0]           ct;
  logic [WIDTH-1:0]     sum_spec, sum_exact;
  logic                 err;
  logic                 seg_rows_agree;

  logic                 accept, load_spec, load_exact, cnt_inc;
  logic                 in_ready_c, out_valid_c;

  logic [WIDTH-1:0]     s_q;
  logic                 co_q, err_flag_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Carry-in guess for each segment is the generate of the segment below it.
  assign cs    = {g[N-2:0], ci_q};
  assign ct[0] = ci_q;

  for (genvar k = 0; k < N; k++) begin : g_seg
    seg_add3_pg u_spec (
      .a    (a_q[k*SEG_W +: SEG_W]),
      .b    (b_q[k*SEG_W +: SEG_W]),
      .cin  (cs[k]),
      .sum  (sum_spec[k*SEG_W +: SEG_W]),
      .cout (c_s[k]),
      .p    (p[k]),
      .g    (g[k])
    );

    seg_add3_pg u_exact (
      .a    (a_q[k*SEG_W +: SEG_W]),
      .b    (b_q[k*SEG_W +: SEG_W]),
      .cin  (ct[k]),
      .sum  (sum_exact[k*SEG_W +: SEG_W]),
      .cout (c_x[k]),
      .p    (p_x[k]),
      .g    (g_x[k])
    );

    assign ct[k+1] = g[k] | (p[k] & ct[k]);
  end

  // A guess can only be wrong by missing a carry that ripples through a propagate segment.
  assign err = |(ct[N-1:1] & ~cs[N-1:1]);

  // The exact row repeats p/g and its carry-outs must equal the lookahead chain;
  // the speculative row's carry-outs must follow g | p&cin.
  assign seg_rows_agree = (p_x == p) && (g_x == g) && (c_x == ct[N:1]) &&
                          (c_s == (g | (p & cs)));

  a_seg_rows_agree : assert property (@(posedge clk) disable iff (rst) seg_rows_agree);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    load_spec   = 1'b0;
    load_exact  = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        cnt_inc = err;
        if (approx_q || !err) begin
          load_spec = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        load_exact = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only in the accept cycle; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= a;
      b_q      <= b;
      ci_q     <= ci;
      approx_q <= approx_mode;
    end
  end

  // Result registers hold steady through DONE until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= '0;
      co_q       <= 1'b0;
      err_flag_q <= 1'b0;
    end else if (load_spec) begin
      s_q        <= sum_spec;
      co_q       <= c_s[N-1];
      err_flag_q <= err;
    end else if (load_exact) begin
      s_q        <= sum_exact;
      co_q       <= ct[N];
      err_flag_q <= 1'b1;
    end
  end

  // Misspeculation counter, saturating at all-ones, counts in both modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (cnt_inc && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_c;
  assign s         = s_q;
  assign co        = co_q;
  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spec_seg_adder_vl.sv
// Scoreboard bench for spec_seg_adder_vl: default instance plus a 2-bit-counter instance in lockstep.
// Latency: expected 2 or 3 cycles from accept, checked on the first out_valid cycle.
// Backpressure: out_ready randomised, or held low/high for directed windows.
module tb_spec_seg_adder_vl;

  localparam int W  = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready, in_ready2;
  logic [W-1:0]  a = '0, b = '0;
  logic          ci = 1'b0, approx_mode = 1'b0;
  logic          out_valid, out_valid2;
  logic          out_ready = 1'b0;
  logic [W-1:0]  s, s2;
  logic          co, co2, err_flag, err_flag2;
  logic [CW-1:0] err_cnt;
  logic [1:0]    err_cnt2;

  spec_seg_adder_vl #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .approx_mode(approx_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  spec_seg_adder_vl #(.WIDTH(W), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .ci(ci), .approx_mode(approx_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .s(s2), .co(co2), .err_flag(err_flag2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ef;
    int           lat;
    int           cnt;
    int           cnt2;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   model_cnt  = 0;
  int   model_cnt2 = 0;
  int   rdy_mode   = 0;   // 0 random, 1 held low, 2 held high

  // Reference: exact sum is plain a+b+ci; true carry into a segment is the carry of the
  // low-order slice; the guessed carry is whether the slice below overflows on its own.
  function automatic exp_t model(input int av, input int bv, input int civ, input int apx);
    exp_t e;
    int   spec_s = 0, spec_co = 0, exact, seg, cs, ct, m, ak, bk;
    bit   err = 0;
    exact = av + bv + civ;
    for (int k = 0; k < W / 3; k++) begin
      ak = (av >> (3 * k)) & 7;
      bk = (bv >> (3 * k)) & 7;
      if (k == 0) begin
        cs = civ;
        ct = civ;
      end else begin
        cs = ((((av >> (3 * (k - 1))) & 7) + ((bv >> (3 * (k - 1))) & 7)) >= 8) ? 1 : 0;
        m  = (1 << (3 * k)) - 1;
        ct = (((av & m) + (bv & m) + civ) >= (1 << (3 * k))) ? 1 : 0;
      end
      if (ct == 1 && cs == 0) err = 1;
      seg    = ak + bk + cs;
      spec_s = spec_s | ((seg & 7) << (3 * k));
      if (k == W / 3 - 1) spec_co = seg >> 3;
    end
    if (apx != 0 || !err) begin
      e.s = W'(spec_s); e.co = spec_co[0]; e.ef = err; e.lat = 2;
    end else begin
      e.s = W'(exact & 'hFFF); e.co = exact[W]; e.ef = 1'b1; e.lat = 3;
    end
    e.cnt = 0; e.cnt2 = 0; e.acc = 0;
    return e;
  endfunction

  // out_ready moves shortly after the rising edge so the negedge monitor sees it settled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares every DONE cycle against the head of the scoreboard, pops on handshake.
  initial begin
    exp_t e;
    bit   prev_vld  = 0;
    bit   idle_chk  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 0;
        idle_chk = 0;
      end else begin
        if (idle_chk) begin
          check("idle_after_release", 64'({out_valid, in_ready}), 64'(2'b01));
          idle_chk = 0;
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out_valid: out_valid=1 with empty scoreboard, required 0");
          end else begin
            e = q[0];
            if (!prev_vld) check("latency", 64'(cyc - e.acc), 64'(e.lat));
            check("s", 64'(s), 64'(e.s));
            check("co", 64'(co), 64'(e.co));
            check("err_flag", 64'(err_flag), 64'(e.ef));
            check("busy_in_ready", 64'(in_ready), 64'(0));
            if (out_ready) begin
              check("err_cnt", 64'(err_cnt), 64'(e.cnt));
              check("err_cnt_sat", 64'(err_cnt2), 64'(e.cnt2));
              check("sat_inst_result", 64'({out_valid2, s2, co2, err_flag2}),
                    64'({1'b1, e.s, e.co, e.ef}));
              void'(q.pop_front());
              idle_chk = 1;
            end
          end
        end
        prev_vld = out_valid;
      end
    end
  end

  task automatic wait_in_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL in_ready_timeout: in_ready=0 after 30 cycles, required 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Issue one operation; with hold set, keep out_ready low for 5 DONE cycles and poke in_valid.
  task automatic send(input int av, input int bv, input int civ, input int apx, input bit hold);
    exp_t e;
    bit   ok;
    if (hold) rdy_mode = 1;
    wait_in_ready(ok);
    if (!ok) return;
    a = W'(av); b = W'(bv); ci = civ[0]; approx_mode = apx[0];
    in_valid = 1'b1;
    e = model(av, bv, civ, apx);
    if (e.ef) begin
      if (model_cnt < (1 << CW) - 1) model_cnt++;
      if (model_cnt2 < 3) model_cnt2++;
    end
    e.cnt = model_cnt; e.cnt2 = model_cnt2; e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom_range(0, 4095)); b = W'($urandom_range(0, 4095));
    ci = 1'($urandom_range(0, 1)); approx_mode = 1'($urandom_range(0, 1));
    if (hold) begin
      for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        a = W'($urandom_range(0, 4095)); b = W'($urandom_range(0, 4095));
        check("hold_in_ready", 64'({in_ready, out_valid}), 64'(2'b01));
        @(negedge clk);
      end
      in_valid = 1'b0;
      rdy_mode = 2;
    end
    wait_drain();
    rdy_mode = 0;
  endtask

  // Start an exact-mode erroring op and assert rst while the block is correcting it.
  task automatic reset_in_fix();
    bit ok;
    wait_in_ready(ok);
    if (!ok) return;
    a = 12'h03F; b = 12'h001; ci = 1'b0; approx_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);            // EVAL
    in_valid = 1'b0;
    @(negedge clk);            // FIX
    check("fix_no_valid", 64'(out_valid), 64'(0));
    rst = 1'b1;
    model_cnt = 0; model_cnt2 = 0;
    q.delete();
    @(negedge clk);
    check("rst_fix_out_valid", 64'(out_valid), 64'(0));
    check("rst_fix_in_ready", 64'(in_ready), 64'(0));
    check("rst_fix_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_fix_err_cnt_sat", 64'(err_cnt2), 64'(0));
    check("rst_fix_outputs", 64'({s, co, err_flag}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_fix_idle", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_outputs", 64'({s, co, err_flag}), 64'(0));
    check("reset_err_cnt", 64'(err_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'(1));

    send('h003, 'h004, 0, 0, 0);
    send('h03F, 'h001, 0, 1, 0);
    send('h03F, 'h001, 0, 0, 0);
    send('h007, 'h000, 1, 0, 0);
    send('hFFF, 'h001, 0, 1, 0);
    send('hFFF, 'h001, 0, 0, 0);
    send('h03F, 'h001, 0, 0, 1);
    send('h123, 'h456, 1, 0, 1);

    reset_in_fix();

    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), (i % 15) == 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spec_seg_adder_vl.md
Name: spec_seg_adder_vl

Overview:
- Variable-latency speculative adder for the approximate-computing CNN datapath.
- Splits a WIDTH-bit add into 3-bit segments; each segment's group propagate/generate comes from a 3-bit ripple segment with group p/g.
- Sits downstream of that segment stage and consumes its p/g. Speculates each segment carry-in from the previous segment's group generate.
- Either returns the speculative sum in approximate mode, or detects misspeculation and spends one extra cycle correcting it in exact mode.

Parameters:
- WIDTH, 12, operand width; must be a multiple of SEG_W.
- ERR_CNT_W, 16, width of the saturating misspeculation counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand handshake valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in
- approx_mode  input  1  1 = return speculative result, no correction
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum
- co  output  1  carry-out
- err_flag  output  1  misspeculation detected for this result
- err_cnt  output  ERR_CNT_W  saturating count of misspeculated operations

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; s=0, co=0, err_flag=0, out_valid=0, err_cnt=0. in_ready is forced to 0 while rst=1.
- Segment definitions: N=WIDTH/SEG_W segments, k=0..N-1. For each segment:
  - p[k] = AND of bitwise (a^b) over the segment.
  - g[k] = carry-out of the segment with carry-in 0.
- Speculative carries: cs[0]=ci; cs[k]=g[k-1] for k≥1.
- True carries: ct[0]=ci; ct[k+1]=g[k] | (p[k] & ct[k]).
- Error: err = OR over k=1..N-1 of (ct[k] & ~cs[k]). Misspeculation is only ever spec=0/true=1.
- Speculative sum: seg_k = (a_k+b_k+cs[k]) mod 8. Speculative co = carry-out of segment N-1 with carry-in cs[N-1].
- Exact sum: seg_k = (a_k+b_k+ct[k]) mod 8; co=ct[N].
- FSM IDLE:
  - in_ready=1.
  - On in_valid: register a, b, ci, approx_mode; go to EVAL.
- FSM EVAL (cycle after accept):
  - Compute spec sum, p, g, ct and err from the registered operands.
  - If approx_mode or !err: load s/co with the speculative result and err_flag=err, then go to DONE.
  - Otherwise go to FIX.
  - If err, err_cnt increments in this cycle (saturates at all-ones), regardless of mode.
- FSM FIX: load s/co with the exact result, err_flag=1, go to DONE.
- FSM DONE:
  - out_valid=1; s, co and err_flag are held stable.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - in_ready=0.
- Latency from accept cycle t: out_valid at t+2 when there is no error or approx_mode=1; at t+3 on the corrected path. Throughput is one operation per ≥3 cycles.
- Input changes outside the accept cycle are ignored.
- rst in any state (including FIX/DONE) returns to the reset values next cycle; the in-flight operation is discarded.

Decomposition:
- Package spec_add_pkg: SEG_W=3 constant, FSM state enum (IDLE, EVAL, FIX, DONE), N derivation function.
- Sub-module seg_add3_pg: combinational 3-bit segment add with carry-in, producing sum, carry-out, group p and group g.
  - Instantiated N times for speculative sums and N times for exact sums.
  - Group p/g are taken from the speculative instances.

Test Plan:
- a=0x003, b=0x004, ci=0, approx=0 -> s=0x007, co=0, err_flag=0, out_valid at t+2, err_cnt=0.
- a=0x03F, b=0x001, ci=0: approx=1 -> s=0x000, err_flag=1 at t+2; approx=0 -> s=0x040, co=0, err_flag=1 at t+3; err_cnt increments once per operation.
- a=0x007, b=0x000, ci=1, approx=0 -> ct[1]=1 vs cs[1]=0; s=0x008, err_flag=1 at t+3.
- a=0xFFF, b=0x001, ci=0: approx=1 -> s=0xFC0, co=0, err_flag=1; approx=0 -> s=0x000, co=1, err_flag=1.
- Hold out_ready=0 for 5 cycles in DONE, with new in_valid pulses during those cycles -> s/co/err_flag stable, in_ready=0, new inputs ignored; release -> IDLE next cycle.
- Reset cases:
  - rst asserted during FIX -> next cycle out_valid=0, err_cnt=0, state IDLE.
  - ERR_CNT_W=2 with 5 error operations -> err_cnt saturates at 3.
